// File: rtl/debug_probe_if.sv
// rtl/debug_probe_if.sv - debug probe signal bundle between a CPU/debugger (master) and the probe (slave)
// Ports: chk_addr/chk_data/chk_pc debug read path; probe_bus probe channels;
//        wb_valid/wb_pc retire stream; bp_en/bp_pc breakpoint; resume/step run control;
//        cpu_halt stall request; rf_/dm_debug_addr/data register-file and data-memory peek.
interface debug_probe_if #(
  parameter int N_PROBE = 65,
  parameter int ADDR_W  = 16
);
  logic [ADDR_W-1:0]    chk_addr;
  logic [31:0]          chk_data;
  logic [31:0]          chk_pc;
  logic [N_PROBE*32-1:0] probe_bus;
  logic                 wb_valid;
  logic [31:0]          wb_pc;
  logic                 bp_en;
  logic [31:0]          bp_pc;
  logic                 resume;
  logic                 step;
  logic                 cpu_halt;
  logic [4:0]           rf_debug_addr;
  logic [31:0]          rf_debug_data;
  logic [7:0]           dm_debug_addr;
  logic [31:0]          dm_debug_data;

  modport slave (
    input  chk_addr, probe_bus, wb_valid, wb_pc, bp_en, bp_pc, resume, step,
           rf_debug_data, dm_debug_data,
    output chk_data, chk_pc, cpu_halt, rf_debug_addr, dm_debug_addr
  );

  modport master (
    output chk_addr, probe_bus, wb_valid, wb_pc, bp_en, bp_pc, resume, step,
           rf_debug_data, dm_debug_data,
    input  chk_data, chk_pc, cpu_halt, rf_debug_addr, dm_debug_addr
  );
endinterface

// File: rtl/debug_probe.sv
// rtl/debug_probe.sv - CPU debug probe: address-mapped read port, PC trace buffer, breakpoint/step FSM
// Ports: clk, rstn (async active-low); bus (debug_probe_if.slave) carrying the debug read
//        path, probe channels, retire stream, breakpoint and run-control signals.
module debug_probe #(
  parameter int N_PROBE     = 65,
  parameter int TRACE_DEPTH = 16,
  parameter int ADDR_W      = 16
) (
  input  logic           clk,
  input  logic           rstn,
  debug_probe_if.slave   bus
);
  localparam int          PTR_W     = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [8:0]  DEPTH_CNT = 9'(TRACE_DEPTH);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_skip;
  logic             r_halt;
  logic [31:0]      r_pc;
  logic [31:0]      r_retire_cnt;
  logic [PTR_W-1:0] r_wptr;
  logic [8:0]       r_count;
  logic [31:0]      r_trace [TRACE_DEPTH];

  logic             w_retire;
  logic             w_bp_hit;
  logic [11:0]      w_idx;
  logic [PTR_W-1:0] w_tidx;
  logic [31:0]      w_trace_rd;
  logic [31:0]      w_probe_rd;
  logic [31:0]      w_status;
  logic [31:0]      w_chk_data;

  // Retires are invisible while halted; the pipeline is stalled anyway.
  assign w_retire = bus.wb_valid && (r_state != HALT);
  // Skip suppresses the breakpoint on the first retire after leaving HALT.
  assign w_bp_hit = bus.bp_en && (bus.wb_pc == bus.bp_pc) && !r_skip;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= RUN;
      r_halt       <= 1'b0;
      r_skip       <= 1'b0;
      r_pc         <= '0;
      r_retire_cnt <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
    end else begin
      if (w_retire) begin
        r_pc         <= bus.wb_pc;
        r_retire_cnt <= r_retire_cnt + 32'd1;
        r_wptr       <= r_wptr + 1'b1;
        r_skip       <= 1'b0;
        if (r_count != DEPTH_CNT) r_count <= r_count + 9'd1;
      end
      case (r_state)
        RUN: begin
          if (w_retire && w_bp_hit) begin
            r_state <= HALT;
            r_halt  <= 1'b1;
          end
        end
        HALT: begin
          if (bus.resume) begin
            r_state <= RUN;
            r_halt  <= 1'b0;
            r_skip  <= 1'b1;
          end else if (bus.step) begin
            r_state <= STEP;
            r_halt  <= 1'b0;
            r_skip  <= 1'b1;
          end
        end
        STEP: begin
          if (w_retire) begin
            r_state <= HALT;
            r_halt  <= 1'b1;
          end
        end
        default: begin
          r_state <= RUN;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  // Trace storage is not reset; entries beyond r_count are masked on read.
  always_ff @(posedge clk) begin
    if (w_retire) r_trace[r_wptr] <= bus.wb_pc;
  end

  assign w_idx = bus.chk_addr[11:0];
  // Entry 0 is the newest, i.e. one slot behind the write pointer.
  assign w_tidx = r_wptr - PTR_W'(1) - w_idx[PTR_W-1:0];
  assign w_trace_rd = ({3'b000, r_count} > w_idx) ? r_trace[w_tidx] : 32'd0;
  assign w_status = {r_state, 21'd0, r_count};

  always_comb begin
    w_probe_rd = 32'd0;
    for (int k = 0; k < N_PROBE; k++) begin
      if (w_idx == 12'(k)) w_probe_rd = bus.probe_bus[k*32 +: 32];
    end
  end

  always_comb begin
    w_chk_data = 32'd0;
    case (bus.chk_addr[15:12])
      4'h0: w_chk_data = w_probe_rd;
      4'h1: w_chk_data = bus.rf_debug_data;
      4'h2: w_chk_data = bus.dm_debug_data;
      4'h3: w_chk_data = w_trace_rd;
      4'h4: begin
        if (w_idx == 12'd0)      w_chk_data = w_status;
        else if (w_idx == 12'd1) w_chk_data = r_retire_cnt;
      end
      default: w_chk_data = 32'd0;
    endcase
  end

  assign bus.chk_data      = w_chk_data;
  assign bus.chk_pc        = r_pc;
  assign bus.cpu_halt      = r_halt;
  assign bus.rf_debug_addr = bus.chk_addr[4:0];
  assign bus.dm_debug_addr = bus.chk_addr[7:0];
endmodule

// File: doc/debug_probe.md
DEBUG_PROBE -- requirements
Module: debug_probe

Interface
REQ-001 Parameters SHALL be: N_PROBE, default 65, number of 32-bit probe channels; TRACE_DEPTH, default 16, trace entries (power of two, 2..256); ADDR_W, default 16, debug address width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  system clock; all state updates on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- chk_addr  in  ADDR_W  debug address.
- chk_data  out  32  debug read data, combinational.
- chk_pc  out  32  PC of the last retired instruction, registered.
- probe_bus  in  N_PROBE*32  probe channel k at bits [32k+31:32k].
- wb_valid  in  1  an instruction retires this cycle.
- wb_pc  in  32  PC of the retiring instruction.
- bp_en  in  1  breakpoint enable.
- bp_pc  in  32  breakpoint PC.
- resume  in  1  single-cycle resume request.
- step  in  1  single-cycle single-step request.
- cpu_halt  out  1  pipeline stall request, registered.
- rf_debug_addr  out  5  register-file read index, equal to chk_addr[4:0].
- rf_debug_data  in  32  register-file read data.
- dm_debug_addr  out  8  data-memory read index, equal to chk_addr[7:0].
- dm_debug_data  in  32  data-memory read data.

Function
REQ-003 chk_data SHALL be decoded from chk_addr[15:12] with the following map:
- 0x0: probe channel chk_addr[11:0]; 0 when the index is >= N_PROBE.
- 0x1: rf_debug_data.
- 0x2: dm_debug_data.
- 0x3: trace entry chk_addr[11:0]; 0 is the most recent entry.
- 0x4: status register at offset 0; retire counter at offset 1; 0 at any other offset.
- any other value: 0.
REQ-004 A trace read with index >= the current trace count SHALL return 0.
REQ-005 The status word SHALL be {state[1:0] in bits 31:30, 21'b0, trace count[8:0]}, with encoding RUN=00, HALT=01, STEP=10.
REQ-006 The FSM SHALL have three states: RUN, HALT, STEP.
REQ-007 In RUN, a retire with bp_en=1 and wb_pc==bp_pc SHALL move the FSM to HALT on the next edge, unless the skip flag is set.
REQ-008 In HALT, resume=1 SHALL move the FSM to RUN; resume SHALL win over step in the same cycle.
REQ-009 In HALT, step=1 with resume=0 SHALL move the FSM to STEP.
REQ-010 In STEP, the first retire SHALL move the FSM to HALT on the next edge.
REQ-011 resume and step SHALL be ignored outside HALT.
REQ-012 cpu_halt SHALL be 1 exactly while the FSM is in HALT; it is a registered output, so it rises one cycle after the breakpoint retire.
REQ-013 A skip flag SHALL be set on every HALT exit and cleared by the next retire; while it is set, the breakpoint SHALL NOT fire, so resuming from a breakpoint PC makes forward progress.
REQ-014 A retire is wb_valid=1 while the FSM is not in HALT; wb_valid in HALT SHALL be ignored entirely.
REQ-015 On each retire, the block SHALL:
- register wb_pc into chk_pc;
- increment the 32-bit retire counter, wrapping from 0xFFFFFFFF to 0;
- write wb_pc into the trace buffer.
REQ-016 The trace buffer SHALL be circular, with a write pointer modulo TRACE_DEPTH.
REQ-017 The trace count SHALL increment per retire and saturate at TRACE_DEPTH; when full, the oldest entry SHALL be overwritten.
REQ-018 The breakpoint-retire instruction itself SHALL be traced and counted.
REQ-019 Trace and status reads SHALL reflect state as of the last clock edge, with no read side effects.

Reset
REQ-020 When rstn=0, asynchronously, the block SHALL set:
- FSM to RUN;
- cpu_halt=0;
- chk_pc=0;
- retire counter=0;
- trace count=0 and write pointer=0;
- skip flag=0.
Trace storage contents need not be reset; they are masked by the count.
REQ-021 Reset asserted in HALT or STEP SHALL return the block to RUN with cpu_halt=0 immediately, without waiting for a clock edge.
REQ-022 The first active edge after rstn deasserts SHALL process inputs normally.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Probe map: probe k = 0x1000+k; read 0x0000, 0x0040, 0x0041 -> 0x1000, 0x1040, 0; read 0x1005 -> rf_debug_data with rf_debug_addr=5; read 0x5000 -> 0.
- Trace wrap: 20 retires with PCs 0x100,0x104,...,0x14C -> count=16; 0x3000=0x14C; 0x300F=0x110; 0x3010=0; retire counter=20.
- Breakpoint/resume: bp_pc=0x200, bp_en=1, retire at 0x200 -> cpu_halt=1 next cycle; status[31:30]=01; chk_pc=0x200. Then resume -> RUN; a retire at 0x200 does not re-halt; the next retire at 0x200 halts.
- Single step: in HALT, pulse step -> cpu_halt=0; retire at 0x204 -> HALT next cycle; chk_pc=0x204; count +1. A wb_valid during HALT changes no state.
- Simultaneous and async reset: resume and step in the same HALT cycle -> RUN. rstn pulled low mid-HALT between edges -> cpu_halt=0, count=0, chk_pc=0 immediately.
